rv_multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32 core. It fetches instruction words from instruction memory over a valid handshake and holds the current word in an instruction register that feeds the field decoder. It also sequences the ALU start/done handshake and register-file write-back, and owns the PC and retired-instruction counter. Only R-type (opcode 7'b0110011) is executed; any other opcode raises a sticky trap.

---
 rtl/rv_pkg.sv | 35 +++
 rtl/rv_watchdog_counter.sv | 31 +++
 rtl/rv_multicycle_sequencer.sv | 128 ++++++++++++
 tb/tb_rv_multicycle_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 multi-cycle core: sequencer states,
// opcode constants and trap cause encodings.
package rv_pkg;

  typedef enum logic [2:0] {
    STATE_FETCH  = 3'd0,
    STATE_DECODE = 3'd1,
    STATE_EXEC   = 3'd2,
    STATE_WB     = 3'd3,
    STATE_TRAP   = 3'd4
  } rv_state_e;

  // Plain vector aliases of the state enum for code that keeps state in logic
  localparam logic [2:0] ST_FETCH  = STATE_FETCH;
  localparam logic [2:0] ST_DECODE = STATE_DECODE;
  localparam logic [2:0] ST_EXEC   = STATE_EXEC;
  localparam logic [2:0] ST_WB     = STATE_WB;
  localparam logic [2:0] ST_TRAP   = STATE_TRAP;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd3;

  function automatic logic is_rtype(input logic [31:0] instr);
    return instr[6:0] == OP_RTYPE;
  endfunction

endpackage

// File: rtl/rv_watchdog_counter.sv
// Loadable down-counter that flags the last cycle of a bounded wait; shared by
// the ALU handshake and future memory waits.
module rv_watchdog_counter #(
  parameter int unsigned LOAD_VALUE = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = $clog2(LOAD_VALUE + 1);
  localparam logic [W-1:0] LOAD_CNT = W'(LOAD_VALUE);

  logic [W-1:0] r_count;

  // A count of 1 marks the final permitted cycle; 0 means idle, never expired
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_CNT;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle control FSM: fetch, decode, ALU handshake and write-back for
// R-type instructions, with a sticky trap on anything it cannot execute.
module rv_multicycle_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction_code,
  output logic        o_decode_en,
  output logic        o_alu_start,
  input  logic        i_alu_done,
  output logic        o_rf_we,
  output logic [31:0] o_pc,
  output logic [31:0] o_instret,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instret;
  logic [31:0] r_instr;
  logic        r_imem_req;
  logic        r_alu_start;
  logic [1:0]  r_trap_cause;

  logic        w_wd_load;
  logic        w_wd_en;
  logic        w_expire;
  logic        w_done_ok;
  logic        w_pc_misaligned;

  assign w_wd_load       = (r_state == ST_DECODE);
  assign w_wd_en         = (r_state == ST_EXEC);
  assign w_done_ok       = i_alu_done && !r_alu_start;
  assign w_pc_misaligned = (r_pc[1:0] != 2'b00);

  rv_watchdog_counter #(
    .LOAD_VALUE (ALU_TIMEOUT)
  ) u_alu_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_wd_load),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  // imem_req is registered so it rises one edge after reset and, after WB,
  // is already high on the first FETCH cycle of the next instruction.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_instret    <= '0;
      r_instr      <= '0;
      r_imem_req   <= 1'b0;
      r_alu_start  <= 1'b0;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (!r_imem_req) begin
            if (w_pc_misaligned) begin
              r_state      <= ST_TRAP;
              r_trap_cause <= CAUSE_MISALIGN;
            end else begin
              r_imem_req <= 1'b1;
            end
          end else if (i_imem_valid) begin
            r_instr    <= i_imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_rtype(r_instr)) begin
            r_state     <= ST_EXEC;
            r_alu_start <= 1'b1;
          end else begin
            r_state      <= ST_TRAP;
            r_trap_cause <= CAUSE_ILLEGAL;
          end
        end
        // Done outranks the watchdog, so a done on the last allowed cycle retires
        ST_EXEC: begin
          if (w_done_ok) begin
            r_state <= ST_WB;
          end else if (w_expire) begin
            r_state      <= ST_TRAP;
            r_trap_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_WB: begin
          r_pc       <= r_pc + 32'd4;
          r_instret  <= r_instret + 32'd1;
          r_imem_req <= 1'b1;
          r_state    <= ST_FETCH;
        end
        ST_TRAP: begin
          r_state <= ST_TRAP;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign o_imem_req         = r_imem_req;
  assign o_imem_addr        = r_pc;
  assign o_instruction_code = r_instr;
  assign o_decode_en        = (r_state == ST_DECODE);
  assign o_alu_start        = r_alu_start;
  assign o_rf_we            = (r_state == ST_WB) && (r_instr[11:7] != 5'd0);
  assign o_pc               = r_pc;
  assign o_instret          = r_instret;
  assign o_trap             = (r_state == ST_TRAP);
  assign o_trap_cause       = r_trap_cause;

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Self-checking bench for rv_multicycle_sequencer: a per-cycle vector table for
// the best-case instruction, directed corner cases and randomized instructions.
module tb_rv_multicycle_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic        aluDone;

  logic        req, decEn, aluStart, rfWe, trap;
  logic [31:0] addr, ir, pc, instret;
  logic [1:0]  cause;

  logic        wrapReq, wrapDecEn, wrapAluStart, wrapRfWe, wrapTrap;
  logic [31:0] wrapAddr, wrapIr, wrapPc, wrapInstret;
  logic [1:0]  wrapCause;

  logic        misReq, misDecEn, misAluStart, misRfWe, misTrap;
  logic [31:0] misAddr, misIr, misPc, misInstret;
  logic [1:0]  misCause;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mPc, mInstret, expIr;
  logic        misReqSeen = 1'b0;

  always #5 clk = ~clk;

  rv_multicycle_sequencer #(.RESET_PC(32'h0000_0000), .ALU_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(reset), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_valid(imemValid), .i_imem_rdata(imemRdata), .o_instruction_code(ir),
    .o_decode_en(decEn), .o_alu_start(aluStart), .i_alu_done(aluDone),
    .o_rf_we(rfWe), .o_pc(pc), .o_instret(instret), .o_trap(trap),
    .o_trap_cause(cause)
  );

  rv_multicycle_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .i_clk(clk), .i_reset(reset), .o_imem_req(wrapReq), .o_imem_addr(wrapAddr),
    .i_imem_valid(imemValid), .i_imem_rdata(imemRdata), .o_instruction_code(wrapIr),
    .o_decode_en(wrapDecEn), .o_alu_start(wrapAluStart), .i_alu_done(aluDone),
    .o_rf_we(wrapRfWe), .o_pc(wrapPc), .o_instret(wrapInstret), .o_trap(wrapTrap),
    .o_trap_cause(wrapCause)
  );

  rv_multicycle_sequencer #(.RESET_PC(32'h0000_0002)) dutMis (
    .i_clk(clk), .i_reset(reset), .o_imem_req(misReq), .o_imem_addr(misAddr),
    .i_imem_valid(imemValid), .i_imem_rdata(imemRdata), .o_instruction_code(misIr),
    .o_decode_en(misDecEn), .o_alu_start(misAluStart), .i_alu_done(aluDone),
    .o_rf_we(misRfWe), .o_pc(misPc), .o_instret(misInstret), .o_trap(misTrap),
    .o_trap_cause(misCause)
  );

  // The misaligned-reset core must never issue a fetch at any point in the run
  always @(negedge clk) begin
    if (misReq === 1'b1) misReqSeen = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Asserts reset away from any clock edge, with a stray fetch response present
  task automatic applyReset();
    reset     = 1'b1;
    imemValid = 1'b1;
    imemRdata = $urandom;
    aluDone   = 1'b1;
    #1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instret", instret, 32'h0);
    checkOutput("rst_ir", ir, 32'h0);
    checkOutput("rst_strobes", {28'h0, req, decEn, aluStart, rfWe}, 32'h0);
    checkOutput("rst_trap", {31'h0, trap}, 32'h0);
    checkOutput("rst_cause", {30'h0, cause}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    imemValid = 1'b0;
    aluDone   = 1'b0;
    reset     = 1'b0;
    mPc       = 32'h0;
    mInstret  = 32'h0;
    expIr     = 32'h0;
  endtask

  // Runs one instruction: stall = FETCH cycles with req before valid, doneAt =
  // EXEC cycle carrying alu_done (1 = start cycle, 0 = never), abortAt = EXEC
  // cycle on which reset is asserted (0 = none). Called and returns at a negedge.
  task automatic applyStimulus(input logic [31:0] word, input int stall, input int doneAt,
                               input bit noise, input int abortAt);
    int cyc, firstReq, execCycle, reqCnt, decCnt, startCnt, weCnt, endCyc, kind;
    bit finished;
    cyc = 0; firstReq = -1; execCycle = 0; reqCnt = 0; decCnt = 0;
    startCnt = 0; weCnt = 0; endCyc = 0; finished = 1'b0;
    if (word[6:0] != 7'b0110011)          kind = 1;
    else if (doneAt >= 2 && doneAt <= TO) kind = 0;
    else                                   kind = 2;

    while (!finished && cyc < 300) begin
      if (trap === 1'b1) begin
        finished = 1'b1;
      end else if (instret !== mInstret) begin
        finished = 1'b1;
        endCyc   = cyc;
      end else begin
        checkOutput("instr_reg", ir, expIr);
        if (req === 1'b1) begin
          if (firstReq < 0) firstReq = cyc;
          reqCnt++;
          checkOutput("imem_addr", addr, mPc);
        end
        if (decEn === 1'b1) decCnt++;
        if (aluStart === 1'b1) begin
          startCnt++;
          execCycle = 1;
        end else if (execCycle > 0) begin
          execCycle++;
        end
        if (rfWe === 1'b1) weCnt++;
        if (abortAt > 0 && execCycle == abortAt) begin
          #2;
          applyReset();
          return;
        end
        if (req === 1'b1) imemValid = (reqCnt == stall + 1);
        else              imemValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        imemRdata = (req === 1'b1 && imemValid) ? word : $urandom;
        if (req === 1'b1 && imemValid) expIr = word;
        aluDone = (execCycle > 0 && execCycle == doneAt) ||
                  (noise && execCycle <= 1 && $urandom_range(0, 1) == 1);
        @(negedge clk);
        cyc++;
      end
    end
    imemValid = 1'b0;
    aluDone   = 1'b0;

    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL bound: no retire or trap within %0d cycles, expected outcome kind %0d",
               cyc, kind);
      return;
    end
    checkOutput("trap", {31'h0, trap}, (kind != 0) ? 32'd1 : 32'd0);
    checkOutput("trap_cause", {30'h0, cause}, 32'(kind));
    checkOutput("decode_cnt", 32'(decCnt), 32'd1);
    checkOutput("alu_start_cnt", 32'(startCnt), (kind == 1) ? 32'd0 : 32'd1);
    checkOutput("rf_we_cnt", 32'(weCnt), (kind == 0 && word[11:7] != 5'd0) ? 32'd1 : 32'd0);
    if (kind == 0) begin
      checkOutput("cycles", 32'(endCyc - firstReq), 32'(stall + doneAt + 3));
      mPc      = mPc + 32'd4;
      mInstret = mInstret + 32'd1;
    end
    if (kind == 2) checkOutput("exec_cycles", 32'(execCycle), 32'(TO));
    checkOutput("pc", pc, mPc);
    checkOutput("instret", instret, mInstret);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] rdata;
    logic        done;
    logic        req;
    logic        dec;
    logic        start;
    logic        we;
    logic [31:0] ir;
    logic [31:0] pcv;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] word;
    int          stall, doneAt;

    // Best-case add x3,x1,x2 from reset, one row per cycle, with a stray valid
    // while req is low and another during DECODE
    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h002081B3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 32'h0};
    vecs[2] = '{1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h002081B3, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h002081B3, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h002081B3, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h002081B3, 32'h4, 32'h1};

    applyReset();
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("vec%0d_req", i), {31'h0, req}, {31'h0, vecs[i].req});
      checkOutput($sformatf("vec%0d_decode_en", i), {31'h0, decEn}, {31'h0, vecs[i].dec});
      checkOutput($sformatf("vec%0d_alu_start", i), {31'h0, aluStart}, {31'h0, vecs[i].start});
      checkOutput($sformatf("vec%0d_rf_we", i), {31'h0, rfWe}, {31'h0, vecs[i].we});
      checkOutput($sformatf("vec%0d_ir", i), ir, vecs[i].ir);
      checkOutput($sformatf("vec%0d_pc", i), pc, vecs[i].pcv);
      checkOutput($sformatf("vec%0d_instret", i), instret, vecs[i].ret);
      imemValid = vecs[i].valid;
      imemRdata = vecs[i].rdata;
      aluDone   = vecs[i].done;
      @(negedge clk);
    end
    mPc = 32'h4; mInstret = 32'h1; expIr = 32'h002081B3;

    checkOutput("wrap_pc", wrapPc, 32'h0);
    checkOutput("wrap_instret", wrapInstret, 32'h1);
    checkOutput("wrap_trap", {31'h0, wrapTrap}, 32'h0);
    checkOutput("mis_trap", {31'h0, misTrap}, 32'h1);
    checkOutput("mis_cause", {30'h0, misCause}, 32'h3);
    checkOutput("mis_pc", misPc, 32'h2);

    // Memory stall with noise, then rd=0
    applyStimulus(32'h002081B3, 3, 2, 1'b1, 0);
    applyStimulus(32'h00208033, 0, 2, 1'b0, 0);

    // Illegal opcode: trap must be sticky while inputs keep toggling
    applyStimulus(32'h00000013, 0, 2, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      imemValid = 1'($urandom_range(0, 1));
      aluDone   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("trap_hold", {31'h0, trap}, 32'h1);
      checkOutput("trap_hold_cause", {30'h0, cause}, 32'h1);
      checkOutput("trap_hold_strobes", {28'h0, req, decEn, aluStart, rfWe}, 32'h0);
      checkOutput("trap_hold_pc", pc, mPc);
    end
    imemValid = 1'b0;
    aluDone   = 1'b0;
    applyReset();

    // ALU timeout, then done exactly on the last allowed EXEC cycle
    applyStimulus(32'h002081B3, 0, 0, 1'b0, 0);
    applyReset();
    applyStimulus(32'h002081B3, 1, TO, 1'b0, 0);

    // Reset in EXEC after a retirement, then fetch restarts from RESET_PC
    applyStimulus(32'h002081B3, 0, 3, 1'b0, 2);
    applyStimulus(32'h002081B3, 0, 2, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      word = $urandom;
      if ($urandom_range(0, 9) < 7) word[6:0] = 7'b0110011;
      stall  = int'($urandom_range(0, 3));
      doneAt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 1));
      applyStimulus(word, stall, doneAt, 1'b1, 0);
      if (trap === 1'b1) applyReset();
    end

    checkOutput("mis_req_never", {31'h0, misReqSeen}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
